// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit: iterative MULT/MULTU/DIV/DIVU with MTHI/MTLO writes.
// Latency: iterative ops hold busy for 33 cycles (32 RUN + 1 FIX); MTHI/MTLO in 1 edge.
// Backpressure: stall is raised while busy to any instruction touching HI/LO.
//
// Ports: clk, rst_n (async active-low); funct, hi_write, lo_write, mem_to_reg from
// decode; rs_data/rt_data operands; hi/lo register outputs; busy; stall (combinational).
// Build option: define HILO_FAST_MUL_EN for single-edge MULT/MULTU (divide stays iterative).
module hilo_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  funct,
  input  logic [1:0]  hi_write,
  input  logic [1:0]  lo_write,
  input  logic [2:0]  mem_to_reg,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
  state_t state_q, state_d;

  logic [4:0]  cnt_q;
  logic [31:0] acc_hi_q, acc_lo_q, mcand_q;
  logic        is_div_q, neg_q_q, neg_r_q;

  logic        idle, both_wr, is_mul, is_dvo, op_signed;
  logic        start_iter, mthi_go, mtlo_go;
  logic [31:0] rs_mag, rt_mag;

  assign idle      = (state_q == S_IDLE);
  assign busy      = !idle;
  assign both_wr   = (hi_write == 2'b11) && (lo_write == 2'b11);
  assign is_mul    = both_wr && ((funct == F_MULT) || (funct == F_MULTU));
  assign is_dvo    = both_wr && ((funct == F_DIV) || (funct == F_DIVU));
  assign op_signed = (funct == F_MULT) || (funct == F_DIV);
  assign mthi_go   = idle && (hi_write == 2'b11) && (lo_write != 2'b11) && (funct == F_MTHI);
  assign mtlo_go   = idle && (lo_write == 2'b11) && (hi_write != 2'b11) && (funct == F_MTLO);

  assign stall = busy && ((hi_write != 2'b00) || (lo_write != 2'b00) ||
                          (mem_to_reg == 3'd3) || (mem_to_reg == 3'd4));

  // Signed ops iterate on magnitudes; 0x80000000 maps to itself, which is its
  // correct unsigned magnitude.
  assign rs_mag = (op_signed && rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
  assign rt_mag = (op_signed && rt_data[31]) ? (~rt_data + 32'd1) : rt_data;

`ifdef HILO_FAST_MUL_EN
  logic        fast_go;
  logic [63:0] mag_prod, fast_prod;
  assign fast_go    = idle && is_mul;
  assign start_iter = idle && is_dvo && (rt_data != 32'd0);
  assign mag_prod   = {32'd0, rs_mag} * {32'd0, rt_mag};
  assign fast_prod  = (op_signed && (rs_data[31] ^ rt_data[31])) ? -mag_prod : mag_prod;
`else
  // Divide by zero is never accepted: HI/LO keep their value, busy stays low.
  assign start_iter = idle && (is_mul || (is_dvo && (rt_data != 32'd0)));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_iter) state_d = S_RUN;
      S_RUN:   if (cnt_q == 5'd31) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One iteration step. Multiply: shift-add with acc_lo holding the multiplier.
  // Divide: restoring, acc_hi = partial remainder, acc_lo shifts dividend out and
  // quotient in. When div_ge holds the true difference fits in 32 bits.
  logic [32:0] mul_sum, div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : 33'd0);
    div_shift = {acc_hi_q, acc_lo_q[31]};
    div_ge    = (div_shift >= {1'b0, mcand_q});
    div_diff  = div_shift[31:0] - mcand_q;
  end

  // Sign fix-up applied in FIX.
  logic [63:0] prod, prod_s;
  logic [31:0] res_hi, res_lo;
  always_comb begin
    prod   = {acc_hi_q, acc_lo_q};
    prod_s = neg_q_q ? -prod : prod;
    res_hi = prod_s[63:32];
    res_lo = prod_s[31:0];
    if (is_div_q) begin
      res_lo = neg_q_q ? -acc_lo_q : acc_lo_q;
      res_hi = neg_r_q ? -acc_hi_q : acc_hi_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi       <= 32'd0;
      lo       <= 32'd0;
      cnt_q    <= 5'd0;
      acc_hi_q <= 32'd0;
      acc_lo_q <= 32'd0;
      mcand_q  <= 32'd0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_iter) begin
            cnt_q    <= 5'd0;
            acc_hi_q <= 32'd0;
            acc_lo_q <= is_dvo ? rs_mag : rt_mag;
            mcand_q  <= is_dvo ? rt_mag : rs_mag;
            is_div_q <= is_dvo;
            neg_q_q  <= op_signed && (rs_data[31] ^ rt_data[31]);
            neg_r_q  <= op_signed && rs_data[31];
          end
`ifdef HILO_FAST_MUL_EN
          if (fast_go) begin
            hi <= fast_prod[63:32];
            lo <= fast_prod[31:0];
          end
`endif
          if (mthi_go) hi <= rs_data;
          if (mtlo_go) lo <= rs_data;
        end
        S_RUN: begin
          cnt_q <= cnt_q + 5'd1;
          if (is_div_q) begin
            acc_hi_q <= div_ge ? div_diff : div_shift[31:0];
            acc_lo_q <= {acc_lo_q[30:0], div_ge};
          end else begin
            acc_hi_q <= mul_sum[32:1];
            acc_lo_q <= {mul_sum[0], acc_lo_q[31:1]};
          end
        end
        S_FIX: begin
          hi <= res_hi;
          lo <= res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
module tb_hilo_muldiv;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  funct;
  logic [1:0]  hi_write, lo_write;
  logic [2:0]  mem_to_reg;
  logic [31:0] rs_data, rt_data;
  logic [31:0] hi, lo;
  logic        busy, stall;

  hilo_muldiv dut (
    .clk(clk), .rst_n(rst_n), .funct(funct), .hi_write(hi_write), .lo_write(lo_write),
    .mem_to_reg(mem_to_reg), .rs_data(rs_data), .rt_data(rt_data),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    string       nm;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] hi_m = 32'd0, lo_m = 32'd0;   // architectural HI/LO model

`ifdef HILO_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic. Returns {HI, LO}.
  function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      6'h18:   ref_op = sa * sb;
      6'h19:   ref_op = ua * ub;
      6'h1a: begin
        q = sa / sb;
        r = sa % sb;
        ref_op = {r[31:0], q[31:0]};
      end
      default: ref_op = {(ua % ub) >> 0, 32'd0} | {32'd0, 32'(ua / ub)};
    endcase
    if (f == 6'h1b) ref_op = {32'(ua % ub), 32'(ua / ub)};
  endfunction

  // Monitor: an iterative result appears when busy falls; pop and compare,
  // including the length of the busy window.
  int  bcnt = 0;
  bit  bprev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bcnt  = 0;
        bprev = 1'b0;
      end else begin
        if (busy) bcnt++;
        else if (bprev) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got hi=%h lo=%h, none expected", hi, lo);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.nm, "_hi"}, hi, e.e_hi);
            chk({e.nm, "_lo"}, lo, e.e_lo);
            chk({e.nm, "_busy_len"}, 32'(bcnt), 32'd33);
          end
          bcnt = 0;
        end
        bprev = busy;
      end
    end
  end

  task automatic set_idle();
    funct      = 6'h21;   // ADDU: no HI/LO access
    hi_write   = 2'b00;
    lo_write   = 2'b00;
    mem_to_reg = 3'd0;
    rs_data    = $urandom;
    rt_data    = $urandom;
  endtask

  // Present an op for one edge, then scramble the operands.
  task automatic issue(input string nm, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    logic [63:0] r;
    funct    = f;
    hi_write = 2'b11;
    lo_write = 2'b11;
    rs_data  = a;
    rt_data  = b;
    @(posedge clk); #1;
    set_idle();
    if (f[1] && b == 32'd0) begin
      chk({nm, "_dz_busy"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk({nm, "_dz_busy2"}, 32'(busy), 32'd0);
      chk({nm, "_dz_hi"}, hi, hi_m);
      chk({nm, "_dz_lo"}, lo, lo_m);
    end else begin
      r    = ref_op(f, a, b);
      hi_m = r[63:32];
      lo_m = r[31:0];
      if (FAST && !f[1]) begin
        chk({nm, "_fast_busy"}, 32'(busy), 32'd0);
        chk({nm, "_fast_hi"}, hi, hi_m);
        chk({nm, "_fast_lo"}, lo, lo_m);
      end else begin
        exp_q.push_back('{hi_m, lo_m, nm});
        chk({nm, "_busy_on"}, 32'(busy), 32'd1);
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    int i;
    for (i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (i == 80) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: busy still %0d after 80 cycles, required 0", nm, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic mt(input bit to_hi, input logic [31:0] v);
    funct    = to_hi ? 6'h11 : 6'h13;
    hi_write = to_hi ? 2'b11 : 2'(($urandom_range(0, 2)));
    lo_write = to_hi ? 2'(($urandom_range(0, 2))) : 2'b11;
    rs_data  = v;
    @(posedge clk); #1;
    set_idle();
    if (to_hi) hi_m = v; else lo_m = v;
    chk(to_hi ? "mthi_hi" : "mtlo_hi", hi, hi_m);
    chk(to_hi ? "mthi_lo" : "mtlo_lo", lo, lo_m);
  endtask

  initial begin
    logic [5:0]  ftab [4];
    logic [31:0] a, b, lo_hold;
    ftab = '{6'h18, 6'h19, 6'h1a, 6'h1b};
    set_idle();
    rst_n = 1'b0;
    mem_to_reg = 3'd3;
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset accepts.
    issue("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle("multu_max");
    chk("multu_max_lit_hi", hi, 32'hFFFF_FFFE);
    chk("multu_max_lit_lo", lo, 32'h0000_0001);

    issue("div_m7_2", 6'h1a, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div_m7_2");
    chk("div_m7_2_lit_lo", lo, 32'hFFFF_FFFD);
    chk("div_m7_2_lit_hi", hi, 32'hFFFF_FFFF);

    issue("div_ovf", 6'h1a, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div_ovf");
    chk("div_ovf_lit_lo", lo, 32'h8000_0000);
    chk("div_ovf_lit_hi", hi, 32'h0);

    issue("divu_dz", 6'h1b, 32'd55, 32'd0);

    mt(1'b0, 32'h1234);
    chk("mtlo_lit", lo, 32'h1234);
    mt(1'b1, 32'hCAFE_0001);

    // MFHI held behind an in-flight divide.
    issue("divu_100_7", 6'h1b, 32'd100, 32'd7);
    mem_to_reg = 3'd3;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!busy) break;
      chk("mfhi_stall", 32'(stall), 32'd1);
    end
    chk("mfhi_stall_drop", 32'(stall), 32'd0);
    chk("mfhi_hi", hi, 32'd2);
    chk("mfhi_lo", lo, 32'd14);
    set_idle();
    @(posedge clk); #1;

    // MTLO and a new MULT presented while busy are ignored; ADDU does not stall.
    lo_hold = lo_m;
    issue("mult_busy", 6'h18, 32'h0001_0003, 32'hFFFF_0007);
    for (int i = 0; i < 3; i++) begin
      funct = 6'h13; lo_write = 2'b11; hi_write = 2'b00; rs_data = 32'h1234;
      @(negedge clk);
      chk("mtlo_busy_stall", 32'(stall), 32'd1);
      chk("mtlo_busy_lo", lo, lo_hold);
      @(posedge clk); #1;
    end
    funct = 6'h18; hi_write = 2'b11; lo_write = 2'b11; rs_data = 32'd9; rt_data = 32'd9;
    @(negedge clk);
    chk("op_busy_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    chk("addu_no_stall", 32'(stall), 32'd0);
    wait_idle("mult_busy");

    // Reset mid-MULT aborts; a new op then completes normally.
    if (!FAST) begin
      issue("mult_abort", 6'h18, 32'd123456, 32'd654321);
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      hi_m = 32'd0;
      lo_m = 32'd0;
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
    end
    issue("mult_3_m4", 6'h18, 32'd3, 32'hFFFF_FFFC);
    wait_idle("mult_3_m4");
    chk("mult_3_m4_lit_hi", hi, 32'hFFFF_FFFF);
    chk("mult_3_m4_lit_lo", lo, 32'hFFFF_FFF4);

    // Randomised mix.
    for (int n = 0; n < 40; n++) begin
      int k;
      k = $urandom_range(0, 5);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      if (k < 4) begin
        issue("rnd", ftab[k], a, b);
        wait_idle("rnd");
      end else begin
        mt(k == 4, a);
      end
    end

    repeat (2) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
